// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: result width, flag bundle, result-stage states
package alu_pkg;

   localparam int ALU_W = 8;

   typedef struct packed {
      logic zero;
      logic neg;
      logic parity;
   } alu_flags_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } res_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational zero/neg/parity flags for one ALU result
// Parity is produced only when ALU_RES_PARITY_EN is defined, otherwise it is 0.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int W = ALU_W
) (
   input  logic [W-1:0] data,
   output alu_flags_t   flags
);

   always_comb begin
      flags      = '0;
      flags.zero = (data == '0);
      flags.neg  = data[W-1];
`ifdef ALU_RES_PARITY_EN
      flags.parity = ^data;
`else
      flags.parity = 1'b0;
`endif
   end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - 2-entry skid buffer for ALU results with flags and delivery counter
// Optional parity flag enabled by ALU_RES_PARITY_EN; port list is identical in both builds.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int W     = ALU_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_parity,
   output logic [CNT_W-1:0] res_count
);

   res_state_t       state_q, state_d;
   logic [W-1:0]     main_data_q, main_data_d;
   logic [W-1:0]     skid_data_q, skid_data_d;
   alu_flags_t       main_flags_q, main_flags_d;
   alu_flags_t       skid_flags_q, skid_flags_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   alu_flags_t in_flags;
   logic       acc;
   logic       take;

   alu_flag_gen #(.W(W)) u_flag_gen (
      .data  (in_data),
      .flags (in_flags)
   );

   assign acc  = in_valid & in_ready_q;
   assign take = (state_q != EMPTY) & out_ready;

   always_comb begin
      state_d      = state_q;
      main_data_d  = main_data_q;
      main_flags_d = main_flags_q;
      skid_data_d  = skid_data_q;
      skid_flags_d = skid_flags_q;
      cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, take};

      case (state_q)
         EMPTY: begin
            if (acc) begin
               state_d      = ONE;
               main_data_d  = in_data;
               main_flags_d = in_flags;
            end
         end
         ONE: begin
            if (acc && !take) begin
               state_d      = FULL;
               skid_data_d  = in_data;
               skid_flags_d = in_flags;
            end else if (acc && take) begin
               main_data_d  = in_data;
               main_flags_d = in_flags;
            end else if (take) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (take) begin
               state_d      = ONE;
               main_data_d  = skid_data_q;
               main_flags_d = skid_flags_q;
            end
         end
         default: state_d = EMPTY;
      endcase

      // Ready is looked ahead from the next state so it can be a plain flop.
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         main_data_q  <= '0;
         main_flags_q <= '0;
         skid_data_q  <= '0;
         skid_flags_q <= '0;
         in_ready_q   <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         main_data_q  <= main_data_d;
         main_flags_q <= main_flags_d;
         skid_data_q  <= skid_data_d;
         skid_flags_q <= skid_flags_d;
         in_ready_q   <= in_ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != EMPTY);
   assign out_data   = main_data_q;
   assign out_zero   = main_flags_q.zero;
   assign out_neg    = main_flags_q.neg;
   assign out_parity = main_flags_q.parity;
   assign res_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage (queue model plus directed checks)
module tb_alu_result_stage;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_zero;
   logic       out_neg;
   logic       out_parity;
   logic [7:0] res_count;

   int n_checks = 0;
   int n_fail   = 0;

   alu_result_stage #(.W(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_parity (out_parity),
      .res_count  (res_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_parity(input logic [7:0] d);
`ifdef ALU_RES_PARITY_EN
      return ^d;
`else
      return 1'b0 & d[0];
`endif
   endfunction

   // Behavioural model: results waiting for writeback, at most two of them.
   logic [7:0] m_q[$];
   logic [7:0] m_cnt;
   logic       m_in_ready;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_cnt      = 8'd0;
         m_in_ready = 1'b1;
      end else begin
         logic m_take;
         logic m_acc;
         m_take = (m_q.size() != 0) && out_ready;
         m_acc  = in_valid && m_in_ready;
         if (m_take) begin
            void'(m_q.pop_front());
            m_cnt = m_cnt + 8'd1;
         end
         if (m_acc) m_q.push_back(in_data);
         m_in_ready = (m_q.size() < 2);
      end
   end

   always @(negedge clk) begin
      chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
      chk("cmp_in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
      chk("cmp_res_count", {24'd0, res_count}, {24'd0, m_cnt});
      if (m_q.size() != 0) begin
         chk("cmp_out_data", {24'd0, out_data}, {24'd0, m_q[0]});
         chk("cmp_out_zero", {31'd0, out_zero}, {31'd0, m_q[0] == 8'd0});
         chk("cmp_out_neg", {31'd0, out_neg}, {31'd0, m_q[0][7]});
         chk("cmp_out_parity", {31'd0, out_parity}, {31'd0, exp_parity(m_q[0])});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int vcnt;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_res_count", {24'd0, res_count}, 32'd0);
      chk("reset_out_data", {24'd0, out_data}, 32'd0);

      // Single result
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      step();
      in_valid = 1'b0;
      chk("single_valid", {31'd0, out_valid}, 32'd1);
      chk("single_data", {24'd0, out_data}, 32'hA5);
      chk("single_neg", {31'd0, out_neg}, 32'd1);
      chk("single_zero", {31'd0, out_zero}, 32'd0);
      step();
      chk("single_count", {24'd0, res_count}, 32'd1);
      chk("single_drained", {31'd0, out_valid}, 32'd0);

      // Backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h00;
      step();
      in_data = 8'h3C;
      step();
      chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
      in_data = 8'h77;
      step();
      step();
      chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_head_data", {24'd0, out_data}, 32'h00);
      out_ready = 1'b1;
      chk("bp_first_zero", {31'd0, out_zero}, 32'd1);
      step();
      chk("bp_second_data", {24'd0, out_data}, 32'h3C);
      chk("bp_second_zero", {31'd0, out_zero}, 32'd0);
      step();
      chk("bp_third_data", {24'd0, out_data}, 32'h77);
      in_valid = 1'b0;
      step();
      chk("bp_count", {24'd0, res_count}, 32'd4);

      // Streaming 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         step();
         chk("stream_valid", {31'd0, out_valid}, 32'd1);
         chk("stream_data", {24'd0, out_data}, i);
      end
      in_valid = 1'b0;
      step();
      chk("stream_count", {24'd0, res_count}, 32'd20);

      // Asynchronous reset with two results buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      step();
      in_data = 8'h22;
      step();
      in_valid = 1'b0;
      chk("prerst_full", {31'd0, in_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_count", {24'd0, res_count}, 32'd0);
      chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("async_rst_data", {24'd0, out_data}, 32'd0);
      step();
      rst = 1'b0;

      // Counter wrap after 256 handshakes
      out_ready = 1'b1;
      vcnt      = 0;
      for (int i = 0; i < 256; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom_range(0, 255));
         step();
         if (out_valid) vcnt++;
      end
      in_valid = 1'b0;
      step();
      chk("wrap_valid_cycles", vcnt, 32'd256);
      chk("wrap_count", {24'd0, res_count}, 32'd0);

      // Parity
      in_valid = 1'b1;
      in_data  = 8'h07;
      step();
      in_valid = 1'b0;
      chk("parity_data", {24'd0, out_data}, 32'h07);
`ifdef ALU_RES_PARITY_EN
      chk("parity_flag", {31'd0, out_parity}, 32'd1);
`else
      chk("parity_flag", {31'd0, out_parity}, 32'd0);
`endif
      step();
      chk("parity_count", {24'd0, res_count}, 32'd1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
